// File: rtl/comp_sched512.sv
`default_nettype none
// ============================================================================
// Module      : comp_sched512
// Description : Feeds 512-bit column words to an external popcount compressor
//               and accumulates the delayed per-word counts into a frame sum.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_sched512 #(
    parameter int COMP_LAT = 1,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_words,
    input  logic                word_valid,
    output logic                word_ready,
    input  logic [511:0]        word_data,
    output logic [511:0]        comp_in,
    input  logic [9:0]          comp_out,
    output logic [CNT_W+9:0]    sum_out,
    output logic                busy,
    output logic                done
);

    localparam int c_ACC_W = CNT_W + 10;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FEED  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [CNT_W-1:0]    r_remaining;
    logic [511:0]        r_comp_in;
    logic                r_in_valid;
    logic [COMP_LAT-1:0] r_tag;
    logic [c_ACC_W-1:0]  r_acc;
    logic [c_ACC_W-1:0]  r_sum;

    logic                w_accept;
    logic                w_start_go;
    logic [COMP_LAT:0]   w_chain;
    logic                w_pipe_empty_next;
    logic [c_ACC_W-1:0]  w_acc_add;
    logic [c_ACC_W-1:0]  w_acc_next;

    assign word_ready = (r_state == c_ST_FEED);
    assign busy       = (r_state == c_ST_FEED) || (r_state == c_ST_DRAIN);
    assign done       = (r_state == c_ST_DONE);
    assign comp_in    = r_comp_in;
    assign sum_out    = r_sum;

    assign w_accept   = word_valid & word_ready;
    assign w_start_go = (r_state == c_ST_IDLE) & start;

    // r_in_valid tags the word currently on comp_in; r_tag carries it until
    // its count appears on comp_out at the top stage.
    assign w_chain           = {r_tag, r_in_valid};
    assign w_pipe_empty_next = (w_chain[COMP_LAT-1:0] == '0);

    assign w_acc_add  = r_tag[COMP_LAT-1] ? {{CNT_W{1'b0}}, comp_out} : '0;
    assign w_acc_next = r_acc + w_acc_add;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = (num_words != '0) ? c_ST_FEED : c_ST_DONE;
                end
            end
            c_ST_FEED: begin
                if (w_accept && (r_remaining == c_CNT_ONE)) begin
                    w_state_next = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_pipe_empty_next) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_remaining <= '0;
            r_comp_in   <= '0;
            r_in_valid  <= 1'b0;
            r_tag       <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
        end else begin
            r_state    <= w_state_next;
            r_comp_in  <= w_accept ? word_data : '0;
            r_in_valid <= w_accept;
            r_tag      <= w_chain[COMP_LAT-1:0];

            if (w_start_go) begin
                r_remaining <= num_words;
                r_acc       <= '0;
                r_sum       <= '0;
            end else begin
                if (w_accept) begin
                    r_remaining <= r_remaining - c_CNT_ONE;
                end
                if (r_tag[COMP_LAT-1]) begin
                    r_acc <= w_acc_next;
                end
            end

            // The published sum only changes once the frame is complete.
            if ((r_state == c_ST_DRAIN) && (w_state_next == c_ST_DONE)) begin
                r_sum <= w_acc_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_comp_sched512.sv
`default_nettype none
// ============================================================================
// Module      : tb_comp_sched512
// Description : Scoreboard bench for comp_sched512 at compressor latencies 1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_sched512;

    localparam int CNT_W = 8;
    localparam int SUM_W = CNT_W + 10;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    localparam int M_RAND   = 0;
    localparam int M_ONES   = 1;
    localparam int M_TOGGLE = 2;
    localparam int M_SEVEN  = 3;
    localparam int M_GAPS   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             start1, start3;
    logic [CNT_W-1:0] num_words;
    logic             word_valid;
    logic [511:0]     word_data;
    logic             ready1, ready3, busy1, busy3, done1, done3;
    logic [511:0]     cin1, cin3;
    logic [9:0]       cout1, cout3;
    logic [SUM_W-1:0] sum1, sum3;

    comp_sched512 #(.COMP_LAT(LAT_A), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .reset(reset), .start(start1), .num_words(num_words),
        .word_valid(word_valid), .word_ready(ready1), .word_data(word_data),
        .comp_in(cin1), .comp_out(cout1), .sum_out(sum1), .busy(busy1), .done(done1)
    );

    comp_sched512 #(.COMP_LAT(LAT_B), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .reset(reset), .start(start3), .num_words(num_words),
        .word_valid(word_valid), .word_ready(ready3), .word_data(word_data),
        .comp_in(cin3), .comp_out(cout3), .sum_out(sum3), .busy(busy3), .done(done3)
    );

    // Compressor models: popcount of comp_in, COMP_LAT cycles late
    logic [9:0] p1;
    logic [9:0] p3 [0:2];
    always @(posedge clk) begin
        p1    <= 10'($countones(cin1));
        p3[0] <= 10'($countones(cin3));
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign cout1 = p1;
    assign cout3 = p3[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned sum;
        int          cyc;
    } exp_t;
    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    task automatic chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [511:0] rand_word();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest pending frame
    always @(negedge clk) begin
        if (!reset) begin
            if (done1) begin
                chk("lat1 done with pending frame", q1.size() > 0, 1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    chk("lat1 sum_out", sum1, e1.sum);
                    chk("lat1 done cycle", cyc, e1.cyc);
                    chk("lat1 busy during done", busy1, 0);
                end
            end
            if (done3) begin
                chk("lat3 done with pending frame", q3.size() > 0, 1);
                if (q3.size() > 0) begin
                    e3 = q3.pop_front();
                    chk("lat3 sum_out", sum3, e3.sum);
                    chk("lat3 done cycle", cyc, e3.cyc);
                    chk("lat3 busy during done", busy3, 0);
                end
            end
        end
    end

    task automatic idle_checks(int unsigned exp_sum);
        chk("lat1 busy idle", busy1, 0);
        chk("lat1 word_ready idle", ready1, 0);
        chk("lat1 sum_out idle", sum1, exp_sum);
        chk("lat3 busy idle", busy3, 0);
        chk("lat3 word_ready idle", ready3, 0);
        chk("lat3 sum_out idle", sum3, exp_sum);
    endtask

    task automatic reset_state_checks();
        chk("lat1 reset word_ready", ready1, 0);
        chk("lat1 reset busy", busy1, 0);
        chk("lat1 reset done", done1, 0);
        chk("lat1 reset sum_out", sum1, 0);
        chk("lat1 reset comp_in zero", cin1 == '0, 1);
        chk("lat3 reset word_ready", ready3, 0);
        chk("lat3 reset busy", busy3, 0);
        chk("lat3 reset done", done3, 0);
        chk("lat3 reset sum_out", sum3, 0);
        chk("lat3 reset comp_in zero", cin3 == '0, 1);
    endtask

    task automatic run_frame(int nw, int mode, bit poke);
        int           sent, it, g;
        int unsigned  exp_sum;
        logic [511:0] w;
        bit           v, s1, s3, pk1, pk3;
        @(negedge clk);
        start1 = 1'b1; start3 = 1'b1;
        num_words = nw[CNT_W-1:0];
        exp_sum = 0;
        if (nw == 0) begin
            q1.push_back('{0, cyc + 1});
            q3.push_back('{0, cyc + 1});
        end
        sent = 0; it = 0;
        while (sent < nw && it < 2000) begin
            @(negedge clk);
            start1 = 1'b0; start3 = 1'b0; num_words = '0;
            chk("lat1 word_ready in feed", ready1, 1);
            chk("lat3 word_ready in feed", ready3, 1);
            word_valid = 1'b0; word_data = '0;
            if (poke && it == 2) begin
                start1 = 1'b1; start3 = 1'b1; num_words = 8'd2;
            end
            w = '0;
            v = 1'b1;
            case (mode)
                M_ONES:   w = '1;
                M_TOGGLE: begin
                    v = (it % 2 == 0);
                    for (int j = 0; j <= sent; j++) w[j] = 1'b1;
                end
                M_SEVEN:  w[6:0] = 7'h7F;
                M_GAPS:   begin
                    v = ($urandom_range(0, 1) == 1);
                    w = rand_word() & rand_word();
                end
                default:  w = rand_word();
            endcase
            if (v) begin
                word_valid = 1'b1;
                word_data  = w;
                exp_sum   += $countones(w);
                sent++;
                if (sent == nw) begin
                    // accept at the coming edge; done COMP_LAT+1 cycles after it
                    q1.push_back('{exp_sum, cyc + LAT_A + 2});
                    q3.push_back('{exp_sum, cyc + LAT_B + 2});
                end
            end
            it++;
        end
        if (nw > 0) begin
            chk("feed finished within bound", sent, nw);
            @(negedge clk);
            word_valid = 1'b0; word_data = '0;
            start1 = 1'b0; start3 = 1'b0; num_words = '0;
            chk("lat1 word_ready after last accept", ready1, 0);
            chk("lat3 word_ready after last accept", ready3, 0);
            chk("lat1 busy in drain", busy1, 1);
            chk("lat3 busy in drain", busy3, 1);
        end
        s1 = 0; s3 = 0; pk1 = 0; pk3 = 0; g = 0;
        while (!(s1 && s3) && g < 100) begin
            @(negedge clk);
            g++;
            start1 = 1'b0; start3 = 1'b0; num_words = '0;
            if (pk1) begin
                chk("lat1 start in done ignored", busy1, 0);
                chk("lat1 sum after done start", sum1, exp_sum);
                pk1 = 0;
            end
            chk("lat1 word_ready low after feed", ready1, 0);
            chk("lat3 word_ready low after feed", ready3, 0);
            if (done1 && !s1) begin
                s1 = 1;
                if (poke) begin start1 = 1'b1; num_words = 8'd3; pk1 = 1; end
            end
            if (done3 && !s3) begin
                s3 = 1;
                if (poke) begin start3 = 1'b1; num_words = 8'd3; pk3 = 1; end
            end
        end
        chk("frame done within bound", s1 && s3, 1);
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0; num_words = '0;
        if (pk1) chk("lat1 start in done ignored", busy1, 0);
        if (pk3) chk("lat3 start in done ignored", busy3, 0);
        idle_checks(exp_sum);
    endtask

    task automatic reset_midframe();
        @(negedge clk);
        start1 = 1'b1; start3 = 1'b1; num_words = 8'd5;
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0; num_words = '0;
        word_valid = 1'b1; word_data = rand_word() | 512'h1;
        @(negedge clk);
        word_data = rand_word() | 512'h1;
        @(negedge clk);
        word_valid = 1'b0; word_data = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        reset_state_checks();
        // a done from the abandoned frame would hit an empty scoreboard
        repeat (10) @(negedge clk);
        idle_checks(0);
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start3 = 1'b0; num_words = '0;
        word_valid = 1'b0; word_data = '0;
        repeat (3) @(negedge clk);
        reset_state_checks();
        reset = 1'b0;

        run_frame(3, M_ONES, 0);
        run_frame(0, M_RAND, 0);
        run_frame(4, M_TOGGLE, 0);
        repeat (4) run_frame($urandom_range(1, 12), M_RAND, 0);
        run_frame($urandom_range(5, 15), M_GAPS, 0);
        run_frame(6, M_RAND, 1);
        run_frame(255, M_ONES, 0);
        reset_midframe();
        run_frame(1, M_SEVEN, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard drained", q1.size() + q3.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comp_sched512.md
COMP_SCHED512 -- requirements
Module: comp_sched512

Interface
REQ-001 Parameter COMP_LAT, default 1, meaning cycles from comp_in presented to matching comp_out valid; legal range 1..8.
REQ-002 Parameter CNT_W, default 8, meaning width of word-count field; max frame 2^CNT_W-1 words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  frame start request; sampled only in IDLE.
REQ-006 num_words  input  CNT_W  words in frame, latched with start.
REQ-007 word_valid  input  1  word_data valid.
REQ-008 word_ready  output  1  controller accepts word this cycle.
REQ-009 word_data  input  512  column word to be counted.
REQ-010 comp_in  output  512  registered drive to compressor input in_col0.
REQ-011 comp_out  input  10  compressor population count of comp_in, COMP_LAT cycles late.
REQ-012 sum_out  output  CNT_W+10  accumulated frame count.
REQ-013 busy  output  1  high in FEED and DRAIN.
REQ-014 done  output  1  one-cycle pulse, frame result final.

Function
REQ-015 FSM states IDLE, FEED, DRAIN, DONE; busy=1 exactly in FEED/DRAIN.
REQ-016 IDLE: start=1, num_words>0 -> FEED; latch num_words into remaining counter; clear accumulator.
REQ-017 IDLE: start=1, num_words=0 -> DONE directly; sum_out=0.
REQ-018 start outside IDLE ignored, no effect on counters or accumulator.
REQ-019 word_ready = 1 iff state FEED (combinational from state only, no dependency on word_valid).
REQ-020 Accept = word_valid & word_ready at an edge; comp_in <= word_data; issue tag enters COMP_LAT-deep tag shift register; remaining decrements by 1.
REQ-021 Edge without accept: comp_in <= 0, tag entry 0.
REQ-022 Word whose comp_in is driven in cycle c: comp_out sampled at end of cycle c+COMP_LAT; accumulator += zero-extended comp_out iff that tag is set.
REQ-023 Accumulator width CNT_W+10; no overflow possible (max (2^CNT_W-1)*512); no saturation logic.
REQ-024 Accept of last word (remaining=1) -> DRAIN; word_ready=0 from next cycle.
REQ-025 Back-to-back accepts every cycle allowed; throughput 1 word/cycle; word_valid gaps do not stall in-flight tags.
REQ-026 DRAIN -> DONE on edge where final tagged result accumulates and tag register becomes empty.
REQ-027 DONE: done=1 for exactly one cycle, then -> IDLE unconditionally; start in DONE ignored.
REQ-028 sum_out = accumulator; updates visible only when done=1 or later; holds final value in IDLE until next accepted start clears it.
REQ-029 Latency: last accept at edge k -> done high in cycle k+COMP_LAT+1.

Reset
REQ-030 reset=1 at edge: state IDLE, word_ready=0, busy=0, done=0, comp_in=0, sum_out=0, tag register and remaining counter cleared.
REQ-031 Reset mid-frame discards in-flight tags; no accumulation or done pulse from pre-reset words.
REQ-032 reset has priority over start and accept in same cycle.

Verification
REQ-033 COMP_LAT=1, start, num_words=3, three words each all-ones, back-to-back -> sum_out=1536, done pulse 2 cycles after third accept, busy low after.
REQ-034 num_words=0 start -> DONE next cycle, done=1 one cycle, sum_out=0, no word_ready.
REQ-035 num_words=4, word_valid toggling 1,0,1,0..., words popcount 1,2,3,4 -> sum_out=10; word_ready stays 1 through gaps.
REQ-036 num_words=255, all-ones words, COMP_LAT=3 -> sum_out=130560, no overflow, done 4 cycles after last accept.
REQ-037 reset asserted while 2 tags in flight -> state IDLE next cycle, no done, sum_out=0; following frame of 1 word popcount 7 -> sum_out=7.
REQ-038 start pulsed during FEED and during DONE -> ignored; remaining count and sum_out unchanged.
